// File: rtl/gemm_dot_accum.sv
// gemm_dot_accum: stallable signed dot-product engine (multiply stage, registered adder tree, framed accumulator).
// Optional macro GEMM_ACC_SAT_EN selects a saturating accumulator with a sticky per-packet out_sat flag.
module gemm_dot_accum #(
  parameter int N     = 8,
  parameter int WIDTH = 16,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [N*WIDTH-1:0]   vec_a,
  input  logic [N*WIDTH-1:0]   vec_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_data,
  output logic                 out_sat
);

  localparam int L  = $clog2(N);
  localparam int PW = 2 * WIDTH;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  logic [N*PW-1:0]        prod_next;
  logic [N*PW-1:0]        prod_reg;
  // Tree nodes in heap order: node 1 is the root, node k has children 2k and 2k+1,
  // nodes N..2N-1 are the (sign-extended) products. Slot k-2 of node holds nodes 2..2N-1.
  logic [(2*N-2)*ACC_W-1:0] node;
  logic [(N-1)*ACC_W-1:0] tree_next;
  logic [(N-1)*ACC_W-1:0] tree_reg;
  // Tag bit 0 belongs to the multiply stage, bit L to the tree root.
  logic [L:0]             tv_reg;
  logic [L:0]             tf_reg;
  logic [L:0]             tl_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign prod_next[gi*PW +: PW] = PW'($signed(vec_a[gi*WIDTH +: WIDTH]))
                                    * PW'($signed(vec_b[gi*WIDTH +: WIDTH]));
      assign node[(N+gi-2)*ACC_W +: ACC_W] = ACC_W'($signed(prod_reg[gi*PW +: PW]));
    end
    for (gi = 1; gi < N; gi++) begin : g_node
      assign tree_next[(gi-1)*ACC_W +: ACC_W] = node[(2*gi-2)*ACC_W +: ACC_W]
                                              + node[(2*gi-1)*ACC_W +: ACC_W];
      if (gi > 1) begin : g_inner
        assign node[(gi-2)*ACC_W +: ACC_W] = tree_reg[(gi-1)*ACC_W +: ACC_W];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg <= '0;
      tree_reg <= '0;
      tv_reg   <= '0;
      tf_reg   <= '0;
      tl_reg   <= '0;
    end else if (!stall) begin
      prod_reg <= prod_next;
      tree_reg <= tree_next;
      tv_reg   <= {tv_reg[L-1:0], in_valid};
      tf_reg   <= {tf_reg[L-1:0], in_valid && in_first};
      tl_reg   <= {tl_reg[L-1:0], in_valid && in_last};
    end
  end

  logic signed [ACC_W-1:0] tree_sum;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  assign tree_sum = tree_reg[ACC_W-1:0];
  // acc_reg is cleared after every last, so a beat without first after a last starts from zero.
  assign acc_base = tf_reg[L] ? '0 : acc_reg;

`ifdef GEMM_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] acc_wide;
  logic           sat_reg;
  logic           sat_next;
  assign acc_wide = {acc_base[ACC_W-1], acc_base} + {tree_sum[ACC_W-1], tree_sum};

  always_comb begin
    acc_next = acc_wide[ACC_W-1:0];
    sat_next = tf_reg[L] ? 1'b0 : sat_reg;
    // Sign disagreement between the guard bit and the MSB means the add left the range.
    if (acc_wide[ACC_W] != acc_wide[ACC_W-1]) begin
      acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      sat_next = 1'b1;
    end
  end
`else
  assign acc_next = acc_base + tree_sum;
  assign out_sat  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef GEMM_ACC_SAT_EN
      sat_reg   <= 1'b0;
      out_sat   <= 1'b0;
`endif
    end else if (!stall) begin
      out_valid <= tv_reg[L] && tl_reg[L];
      if (tv_reg[L]) begin
        if (tl_reg[L]) begin
          out_data <= acc_next;
          acc_reg  <= '0;
`ifdef GEMM_ACC_SAT_EN
          out_sat  <= sat_next;
          sat_reg  <= 1'b0;
`endif
        end else begin
          acc_reg  <= acc_next;
`ifdef GEMM_ACC_SAT_EN
          sat_reg  <= sat_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_gemm_dot_accum.sv
// tb_gemm_dot_accum: directed + randomized bench against a packet-level arithmetic model.
// A second instance with ACC_W=34 exercises accumulator overflow (wrap or clamp under GEMM_ACC_SAT_EN).
module tb_gemm_dot_accum;
  localparam int N = 8, WIDTH = 16, ACC_W = 40, SW = 34, L = $clog2(N);

  logic clk = 0, rst = 0;
  logic in_valid = 0, in_valid_s = 0, in_first = 0, in_last = 0;
  logic [N*WIDTH-1:0] vec_a = '0, vec_b = '0;
  logic in_ready, in_ready_s, out_valid, out_valid_s, out_sat, out_sat_s;
  logic out_ready = 1, out_ready_s = 1;
  logic [ACC_W-1:0] out_data;
  logic [SW-1:0]    out_data_s;

  int checks = 0, errors = 0, cyc = 0, ready_mode = 0, acc_cyc = 0;
  longint exp_q[$], exp_qs[$];
  bit     sat_q[$], sat_qs[$];
  longint macc[2];
  bit     mflag[2];
  longint last_exp;
  bit     last_sat;

  gemm_dot_accum #(.N(N), .WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .vec_a(vec_a), .vec_b(vec_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  gemm_dot_accum #(.N(N), .WIDTH(WIDTH), .ACC_W(SW)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_first(in_first), .in_last(in_last), .vec_a(vec_a), .vec_b(vec_b),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .out_data(out_data_s), .out_sat(out_sat_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [N*WIDTH-1:0] rep(input int v);
    logic [WIDTH-1:0] x;
    x = WIDTH'(v);
    return {N{x}};
  endfunction

  function automatic logic [N*WIDTH-1:0] ramp();
    logic [N*WIDTH-1:0] r;
    for (int i = 0; i < N; i++) r[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
    return r;
  endfunction

  // Packet-level model: exact dot product, then accumulate with wrap or clamp at the DUT's ACC_W.
  task automatic model_beat(input bit sm, input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b,
                            input bit f, input bit l);
    int     w = sm ? SW : ACC_W;
    longint s = 0;
    longint acc;
    bit     fl;
    longint amax = (64'sd1 <<< (w - 1)) - 1;
    longint amin = -(64'sd1 <<< (w - 1));
    for (int i = 0; i < N; i++)
      s += longint'($signed(a[i*WIDTH +: WIDTH])) * longint'($signed(b[i*WIDTH +: WIDTH]));
    acc = (f ? 64'sd0 : macc[sm]) + s;
    fl  = f ? 1'b0 : mflag[sm];
`ifdef GEMM_ACC_SAT_EN
    if (acc > amax) begin acc = amax; fl = 1; end
    else if (acc < amin) begin acc = amin; fl = 1; end
`else
    acc = (acc <<< (64 - w)) >>> (64 - w);
`endif
    if (l) begin
      last_exp = acc;
      last_sat = fl;
      if (sm) begin exp_qs.push_back(acc); sat_qs.push_back(fl); end
      else    begin exp_q.push_back(acc);  sat_q.push_back(fl);  end
      macc[sm]  = 0;
      mflag[sm] = 0;
    end else begin
      macc[sm]  = acc;
      mflag[sm] = fl;
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input bit sm, input logic [N*WIDTH-1:0] a, input logic [N*WIDTH-1:0] b,
                      input bit f, input bit l);
    int guard = 0;
    bit ok;
    vec_a = a; vec_b = b; in_first = f; in_last = l;
    if (sm) in_valid_s = 1; else in_valid = 1;
    forever begin
      #1;
      ok = sm ? in_ready_s : in_ready;
      if (ok) acc_cyc = cyc;
      @(posedge clk);
      if (ok) begin
        model_beat(sm, a, b, f, l);
        break;
      end
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", guard);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 0; in_valid_s = 0;
  endtask

  task automatic wait_out(input string name);
    int guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL %s: got out_valid=0 for %0d cycles expected result", name, guard);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() > 0 || exp_qs.size() > 0 || out_valid || out_valid_s) && guard < 400) begin
      @(negedge clk); guard++;
    end
    if (guard >= 400) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size() + exp_qs.size());
    end
    @(negedge clk);
  endtask

  // Main-instance compare: every cycle out_valid is high the held result must equal the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0d expected none", $signed(out_data));
        end else begin
          chk("result_data", $signed(out_data), exp_q[0]);
          chk("result_sat", longint'(out_sat), longint'(sat_q[0]));
        end
      end
      case (ready_mode)
        0:       out_ready = 1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 0;
      endcase
      #1;
      if (!rst) chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(sat_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid_s) begin
        if (exp_qs.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_small_result: got %0d expected none", $signed(out_data_s));
        end else begin
          chk("small_data", $signed(out_data_s), exp_qs[0]);
          chk("small_sat", longint'(out_sat_s), longint'(sat_qs[0]));
          void'(exp_qs.pop_front());
          void'(sat_qs.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*WIDTH-1:0] ra, rb;
    int len;
    bit skip_first;
    macc[0] = 0; macc[1] = 0; mflag[0] = 0; mflag[1] = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_data", $signed(out_data), 0);
    chk("reset_out_sat", longint'(out_sat), 0);
    rst = 0;
    @(negedge clk);
    chk("reset_in_ready", longint'(in_ready), 1);

    // Single-beat packet and latency
    send(0, ramp(), rep(1), 1, 1);
    chk("t1_model", last_exp, 36);
    wait_out("t1_wait");
    chk("t1_latency", longint'(cyc - acc_cyc), L + 2);
    chk("t1_data", $signed(out_data), 36);
    wait_idle();

    // Three-beat accumulation
    send(0, rep(2), rep(3), 1, 0);
    send(0, rep(2), rep(3), 0, 0);
    send(0, rep(2), rep(3), 0, 1);
    chk("t2_model", last_exp, 144);
    wait_idle();

    // Most negative operands
    send(0, rep(-32768), rep(-32768), 1, 1);
    chk("t3_model", last_exp, 64'sd8589934592);
    wait_out("t3_wait");
    chk("t3_data", $signed(out_data), 64'sd8589934592);
    chk("t3_sat", longint'(out_sat), 0);
    wait_idle();

    // Back-to-back results under a long output stall
    ready_mode = 2;
    send(0, ramp(), rep(1), 1, 1);
    send(0, rep(-1), rep(1), 1, 1);
    chk("t4_model", last_exp, -8);
    wait_out("t4_wait");
    repeat (10) begin
      @(negedge clk); #2;
      chk("t4_hold_data", $signed(out_data), 36);
      chk("t4_in_ready", longint'(in_ready), 0);
    end
    ready_mode = 0;
    @(negedge clk); #2;
    @(negedge clk); #2;
    chk("t4_next_valid", longint'(out_valid), 1);
    chk("t4_next_data", $signed(out_data), -8);
    wait_idle();

    // Accumulator overflow at ACC_W=34
    for (int i = 0; i < 4; i++) send(1, rep(32767), rep(32767), i == 0, i == 3);
`ifdef GEMM_ACC_SAT_EN
    chk("t5_model", last_exp, 64'sd8589934591);
    chk("t5_model_sat", longint'(last_sat), 1);
`else
    chk("t5_model", last_exp, -64'sd2097120);
    chk("t5_model_sat", longint'(last_sat), 0);
`endif
    wait_idle();

    // Reset in the middle of a packet
    send(0, rep(5), rep(7), 1, 0);
    send(0, rep(5), rep(7), 0, 0);
    #2 rst = 1;
    macc[0] = 0; mflag[0] = 0;
    @(negedge clk); #1;
    chk("t6_rst_valid", longint'(out_valid), 0);
    rst = 0;
    repeat (8) @(negedge clk);
    send(0, ramp(), rep(1), 1, 1);
    chk("t6_model", last_exp, 36);
    wait_out("t6_wait");
    chk("t6_data", $signed(out_data), 36);
    wait_idle();

    // Randomized packets with bubbles and random backpressure
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 6);
      skip_first = (p > 0) && ($urandom_range(0, 4) == 0);
      for (int j = 0; j < len; j++) begin
        for (int i = 0; i < N; i++) begin
          ra[i*WIDTH +: WIDTH] = WIDTH'($urandom);
          rb[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        send(0, ra, rb, (j == 0) && !skip_first, j == len - 1);
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end
    ready_mode = 0;
    wait_idle();

    chk("queues_drained", longint'(exp_q.size() + exp_qs.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
